// File: rtl/iterative_div_unit_pkg.sv
// Shared types for the iterative divider: op encoding, functional-unit status and FSM states.
package iterative_div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_  = 2'b00,
    DIVU_ = 2'b01,
    REM_  = 2'b10,
    REMU_ = 2'b11
  } div_ops_e;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIVIDE,
    FIXUP,
    DONE
  } div_state_e;

endpackage

// File: rtl/iterative_div_unit_div_step.sv
// One combinational restoring-division step: shift a dividend bit in, subtract the divisor if it fits.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_in,
  input  logic                  dvd_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH:0]   rem_out,
  output logic                  q_bit
);

  logic [DATA_WIDTH+1:0] shifted;
  logic [DATA_WIDTH:0]   diff;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    q_bit   = (shifted >= {2'b00, divisor});
    // When the divisor fits, the true difference is below the divisor, so W+1 bits suffice.
    diff    = shifted[DATA_WIDTH:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : shifted[DATA_WIDTH:0];
  end

endmodule

// File: rtl/iterative_div_unit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) retiring BITS_PER_CYCLE quotient bits per cycle.
module iterative_div_unit
  import iterative_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clk_en_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  div_ops_e              ops_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  div_by_zero_o,
  output fu_state_e             fu_state_o
);

  localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvs_q, result_q;
  logic [DATA_WIDTH:0]   rem_q;
  logic [CNT_W-1:0]      cnt_q;
  logic is_signed_q, is_rem_q, neg_q_q, neg_r_q, dbz_q;
  logic div_zero, sgn_ovf, special, in_signed, in_rem, accept;
  logic [DATA_WIDTH-1:0] special_res, fixup_res, dvd_next;
  logic [DATA_WIDTH:0]   rem_next;

  function automatic logic [DATA_WIDTH-1:0] abs_val(input logic signed [DATA_WIDTH-1:0] v);
    return (v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                     input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  assign in_signed = (ops_i == DIV_) || (ops_i == REM_);
  assign in_rem    = (ops_i == REM_) || (ops_i == REMU_);
  assign div_zero  = (divisor_i == '0);
  assign sgn_ovf   = in_signed && (dividend_i == MIN_VAL) && (divisor_i == '1);
  assign special   = div_zero || sgn_ovf;
  assign accept    = (state_q == IDLE) && valid_i && !flush_i;

  always_comb begin
    if (div_zero) special_res = in_rem ? dividend_i : '1;
    else          special_res = in_rem ? '0 : MIN_VAL;
  end

  // Restoring-step chain: BITS_PER_CYCLE steps resolved in one clock
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    logic [DATA_WIDTH:0]   rem_in, rem_out;
    logic [DATA_WIDTH-1:0] dvd_in, dvd_out;
    logic                  q_bit;
    if (k == 0) begin : g_first
      assign rem_in = rem_q;
      assign dvd_in = dvd_q;
    end else begin : g_next
      assign rem_in = g_step[k-1].rem_out;
      assign dvd_in = g_step[k-1].dvd_out;
    end
    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .rem_in  (rem_in),
      .dvd_bit (dvd_in[DATA_WIDTH-1]),
      .divisor (dvs_q),
      .rem_out (rem_out),
      .q_bit   (q_bit)
    );
    assign dvd_out = {dvd_in[DATA_WIDTH-2:0], q_bit};
  end

  assign rem_next = g_step[BITS_PER_CYCLE-1].rem_out;
  assign dvd_next = g_step[BITS_PER_CYCLE-1].dvd_out;
  assign fixup_res = is_rem_q ? cond_neg(rem_q[DATA_WIDTH-1:0], neg_r_q)
                              : cond_neg(dvd_q, neg_q_q);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)      state_q <= IDLE;
    else if (clk_en_i) state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    fu_state_o = BUSY;
    case (state_q)
      IDLE: begin
        ready_o    = 1'b1;
        fu_state_o = FREE;
        if (valid_i) state_d = special ? DONE : PREP;
      end
      PREP:   state_d = DIVIDE;
      DIVIDE: if (cnt_q == '0) state_d = FIXUP;
      FIXUP:  state_d = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Operand, remainder and counter registers: no reset, loaded at accept/PREP
  always_ff @(posedge clk_i) begin
    if (clk_en_i) begin
      case (state_q)
        IDLE: if (valid_i) begin
          dvd_q       <= dividend_i;
          dvs_q       <= divisor_i;
          is_signed_q <= in_signed;
          is_rem_q    <= in_rem;
        end
        PREP: begin
          if (is_signed_q) begin
            dvd_q <= abs_val(dvd_q);
            dvs_q <= abs_val(dvs_q);
          end
          neg_q_q <= is_signed_q && (dvd_q[DATA_WIDTH-1] ^ dvs_q[DATA_WIDTH-1]);
          neg_r_q <= is_signed_q && dvd_q[DATA_WIDTH-1];
          rem_q   <= '0;
          cnt_q   <= CNT_W'(N - 1);
        end
        DIVIDE: begin
          rem_q <= rem_next;
          dvd_q <= dvd_next;
          cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output register: written on a special-case accept or in FIXUP, held otherwise
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else if (clk_en_i && !flush_i) begin
      if (accept) begin
        dbz_q <= div_zero;
        if (special) result_q <= special_res;
      end else if (state_q == FIXUP) begin
        result_q <= fixup_res;
      end
    end
  end

  assign result_o      = result_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_iterative_div_unit.sv
// Self-checking bench: three divider instances (1, 2, 4 bits/cycle) against a plain-arithmetic model.
module tb_iterative_div_unit;
  import iterative_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, flush;
  logic [31:0] dividend, divisor;
  div_ops_e    ops;
  logic        valid_in [3];
  logic        ready_in [3];
  logic        ready_out[3];
  logic        valid_out[3];
  logic        dbz      [3];
  logic [31:0] res      [3];
  fu_state_e   fu       [3];

  int checks = 0;
  int errors = 0;
  int lat_n[3] = '{34, 18, 10};

  always #5 clk = ~clk;

  iterative_div_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .flush_i(flush),
    .valid_i(valid_in[0]), .ready_o(ready_out[0]), .dividend_i(dividend), .divisor_i(divisor),
    .ops_i(ops), .valid_o(valid_out[0]), .ready_i(ready_in[0]), .result_o(res[0]),
    .div_by_zero_o(dbz[0]), .fu_state_o(fu[0]));

  iterative_div_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .flush_i(flush),
    .valid_i(valid_in[1]), .ready_o(ready_out[1]), .dividend_i(dividend), .divisor_i(divisor),
    .ops_i(ops), .valid_o(valid_out[1]), .ready_i(ready_in[1]), .result_o(res[1]),
    .div_by_zero_o(dbz[1]), .fu_state_o(fu[1]));

  iterative_div_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .flush_i(flush),
    .valid_i(valid_in[2]), .ready_o(ready_out[2]), .dividend_i(dividend), .divisor_i(divisor),
    .ops_i(ops), .valid_o(valid_out[2]), .ready_i(ready_in[2]), .result_o(res[2]),
    .div_by_zero_o(dbz[2]), .fu_state_o(fu[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain integer arithmetic.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input div_ops_e op,
                                  output logic [31:0] r, output logic z, output bit special);
    bit sgn, rem;
    sgn = (op == DIV_) || (op == REM_);
    rem = (op == REM_) || (op == REMU_);
    z = (b == 0);
    special = 1'b0;
    if (b == 0) begin
      r = rem ? a : 32'hFFFF_FFFF;
      special = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = rem ? 32'h0 : 32'h8000_0000;
      special = 1'b1;
    end else if (sgn) begin
      if (rem) r = $signed(a) % $signed(b);
      else     r = $signed(a) / $signed(b);
    end else begin
      r = rem ? a % b : a / b;
    end
  endfunction

  // Issue one op on unit idx; lat = edges after the accept edge until valid_o is seen.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input div_ops_e op, input int hold, input int stall_at, input int stall_len,
                        output logic [31:0] r, output logic z, output int lat);
    logic [31:0] er;
    logic        ez;
    bit          sp;
    ref_div(a, b, op, er, ez, sp);
    dividend = a; divisor = b; ops = op;
    valid_in[idx] = 1'b1;
    ready_in[idx] = (hold == 0);
    @(posedge clk); #1;
    valid_in[idx] = 1'b0;
    dividend = $urandom; divisor = $urandom; ops = div_ops_e'($urandom_range(0, 3));
    lat = 0;
    while (!valid_out[idx] && lat < 300) begin
      if (lat == stall_at) clk_en = 1'b0;
      if (lat == stall_at + stall_len) clk_en = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    clk_en = 1'b1;
    r = res[idx];
    z = dbz[idx];
    for (int h = 0; h < hold; h++) begin
      chk($sformatf("hold%0d result", h), res[idx], er);
      chk($sformatf("hold%0d valid_o", h), {31'd0, valid_out[idx]}, 32'd1);
      chk($sformatf("hold%0d ready_o", h), {31'd0, ready_out[idx]}, 32'd0);
      @(posedge clk); #1;
    end
    ready_in[idx] = 1'b1;
    @(posedge clk); #1;
    ready_in[idx] = 1'b0;
    chk($sformatf("u%0d back to idle", idx), {31'd0, ready_out[idx]}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    div_ops_e    op;
    logic [31:0] exp_r;
    logic        exp_z;
    bit          special;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] r, a, b, er;
    logic        z, ez;
    bit          sp;
    int          lat, mode;
    div_ops_e    op;

    vecs[0]  = '{32'd100,        32'd7,          DIVU_, 32'd14,         1'b0, 1'b0};
    vecs[1]  = '{32'd100,        32'd7,          REMU_, 32'd2,          1'b0, 1'b0};
    vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          DIV_,  32'hFFFF_FFFD,  1'b0, 1'b0};
    vecs[3]  = '{32'hFFFF_FFF9,  32'd2,          REM_,  32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[4]  = '{32'd7,          32'hFFFF_FFFE,  DIV_,  32'hFFFF_FFFD,  1'b0, 1'b0};
    vecs[5]  = '{32'd7,          32'hFFFF_FFFE,  REM_,  32'd1,          1'b0, 1'b0};
    vecs[6]  = '{32'd5,          32'd0,          DIVU_, 32'hFFFF_FFFF,  1'b1, 1'b1};
    vecs[7]  = '{32'd5,          32'd0,          REM_,  32'd5,          1'b1, 1'b1};
    vecs[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  DIV_,  32'h8000_0000,  1'b0, 1'b1};
    vecs[9]  = '{32'h8000_0000,  32'hFFFF_FFFF,  REM_,  32'd0,          1'b0, 1'b1};
    vecs[10] = '{32'h8000_0000,  32'hFFFF_FFFF,  DIVU_, 32'd0,          1'b0, 1'b0};
    vecs[11] = '{32'h8000_0000,  32'hFFFF_FFFF,  REMU_, 32'h8000_0000,  1'b0, 1'b0};
    vecs[12] = '{32'd0,          32'd5,          DIV_,  32'd0,          1'b0, 1'b0};

    for (int i = 0; i < 3; i++) begin
      valid_in[i] = 1'b0;
      ready_in[i] = 1'b0;
    end
    dividend = '0; divisor = '0; ops = DIVU_; flush = 1'b0;

    // Reset must take effect even with the clock enable low.
    rst_n = 1'b0; clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d rst valid_o", i), {31'd0, valid_out[i]}, 32'd0);
      chk($sformatf("u%0d rst ready_o", i), {31'd0, ready_out[i]}, 32'd1);
      chk($sformatf("u%0d rst result_o", i), res[i], 32'd0);
      chk($sformatf("u%0d rst div_by_zero_o", i), {31'd0, dbz[i]}, 32'd0);
      chk($sformatf("u%0d rst fu_state_o", i), {31'd0, fu[i]}, {31'd0, FREE});
    end
    rst_n = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;

    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 13; i++) begin
        run_op(u, vecs[i].a, vecs[i].b, vecs[i].op, 0, -1, 0, r, z, lat);
        chk($sformatf("u%0d vec%0d result", u, i), r, vecs[i].exp_r);
        chk($sformatf("u%0d vec%0d dbz", u, i), {31'd0, z}, {31'd0, vecs[i].exp_z});
        chk($sformatf("u%0d vec%0d latency", u, i), lat, vecs[i].special ? 0 : lat_n[u]);
      end
    end

    // Backpressure: result held for 10 cycles with ready_i low.
    run_op(0, 32'd100, 32'd7, DIVU_, 10, -1, 0, r, z, lat);
    chk("backpressure result", r, 32'd14);

    // Clock enable low for 5 cycles mid-DIVIDE stretches the latency by 5.
    run_op(0, 32'd100, 32'd7, DIVU_, 0, 5, 5, r, z, lat);
    chk("stall result", r, 32'd14);
    chk("stall latency", lat, 32'd39);

    // Flush in DIVIDE cycle 10.
    dividend = 32'd1000; divisor = 32'd3; ops = DIVU_;
    valid_in[0] = 1'b1;
    @(posedge clk); #1;
    valid_in[0] = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("busy fu_state_o", {31'd0, fu[0]}, {31'd0, BUSY});
    chk("busy ready_o", {31'd0, ready_out[0]}, 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush valid_o", {31'd0, valid_out[0]}, 32'd0);
    chk("flush ready_o", {31'd0, ready_out[0]}, 32'd1);
    chk("flush fu_state_o", {31'd0, fu[0]}, {31'd0, FREE});
    run_op(0, 32'd9, 32'd3, DIVU_, 0, -1, 0, r, z, lat);
    chk("post-flush result", r, 32'd3);
    chk("post-flush latency", lat, 32'd34);

    // Random regression on all three widths.
    for (int u = 0; u < 3; u++) begin
      for (int n = 0; n < 25; n++) begin
        mode = $urandom_range(0, 9);
        a = $urandom;
        case (mode)
          0:       b = 32'd0;
          1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          2, 3:    b = $urandom_range(1, 15);
          4:       b = -($urandom_range(1, 15));
          5:       b = $urandom >> $urandom_range(0, 31);
          default: b = $urandom;
        endcase
        op = div_ops_e'($urandom_range(0, 3));
        ref_div(a, b, op, er, ez, sp);
        run_op(u, a, b, op, 0, -1, 0, r, z, lat);
        chk($sformatf("u%0d rnd%0d %h/%h op%0d result", u, n, a, b, op), r, er);
        chk($sformatf("u%0d rnd%0d dbz", u, n), {31'd0, z}, {31'd0, ez});
        chk($sformatf("u%0d rnd%0d latency", u, n), lat, sp ? 0 : lat_n[u]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
